// File: rtl/nearest_block_reducer.sv
// Streaming nearest-hit reducer: folds one candidate beat per block into a single
// per-pixel result (nearest qualifying block and t), with ready/valid on both sides.
//
// state    | meaning
// ST_FIRST | waiting for the first beat of a pixel; accumulator is implicitly empty
// ST_ACCUM | mid-pixel; accumulator holds the best qualifying beat seen so far
module nearest_block_reducer #(
   parameter  int NUM_BLOCKS = 12,
   parameter  int T_WIDTH    = 32,
   parameter  int T_MIN      = 1,
   parameter  int X_WIDTH    = 11,
   parameter  int Y_WIDTH    = 10,
   localparam int IDX_W      = $clog2(NUM_BLOCKS + 1)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               cand_valid_in,
   output logic               cand_ready_out,
   input  logic [IDX_W-1:0]   cand_block_in,
   input  logic               cand_hit_in,
   input  logic [T_WIDTH-1:0] cand_t_in,
   input  logic               cand_last_in,
   input  logic [X_WIDTH-1:0] x_in,
   input  logic [Y_WIDTH-1:0] y_in,
   output logic               res_valid_out,
   input  logic               res_ready_in,
   output logic [IDX_W-1:0]   best_block_out,
   output logic [T_WIDTH-1:0] best_t_out,
   output logic               hit_out,
   output logic [X_WIDTH-1:0] x_out,
   output logic [Y_WIDTH-1:0] y_out,
   output logic               count_err_out
);

   localparam int                 CNT_W    = $clog2(NUM_BLOCKS + 2);
   localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(NUM_BLOCKS + 1);
   localparam logic [CNT_W-1:0]   CNT_GOOD = CNT_W'(NUM_BLOCKS);
   localparam logic [IDX_W-1:0]   MISS_IDX = IDX_W'(NUM_BLOCKS);
   localparam logic [T_WIDTH-1:0] T_MIN_V  = T_WIDTH'(T_MIN);
   localparam logic [T_WIDTH-1:0] T_ALL1   = '1;

   typedef enum logic {ST_FIRST, ST_ACCUM} state_t;

   state_t             state;
   logic [IDX_W-1:0]   acc_block;
   logic [T_WIDTH-1:0] acc_t;
   logic               acc_hit;
   logic [CNT_W-1:0]   acc_cnt;
   logic [X_WIDTH-1:0] acc_x;
   logic [Y_WIDTH-1:0] acc_y;

   logic               beat_ok;
   logic               qual;
   logic [IDX_W-1:0]   base_block, nxt_block;
   logic [T_WIDTH-1:0] base_t, nxt_t;
   logic               base_hit, nxt_hit;
   logic [CNT_W-1:0]   base_cnt, nxt_cnt;
   logic [X_WIDTH-1:0] nxt_x;
   logic [Y_WIDTH-1:0] nxt_y;

   assign cand_ready_out = !res_valid_out || res_ready_in;

   always_comb begin
      beat_ok = cand_valid_in && cand_ready_out;
      qual    = cand_hit_in && (cand_block_in < MISS_IDX) && (cand_t_in >= T_MIN_V);
      if (state == ST_FIRST) begin
         base_block = MISS_IDX;
         base_t     = T_ALL1;
         base_hit   = 1'b0;
         base_cnt   = '0;
         nxt_x      = x_in;
         nxt_y      = y_in;
      end else begin
         base_block = acc_block;
         base_t     = acc_t;
         base_hit   = acc_hit;
         base_cnt   = acc_cnt;
         nxt_x      = acc_x;
         nxt_y      = acc_y;
      end
      nxt_block = base_block;
      nxt_t     = base_t;
      nxt_hit   = base_hit;
      // base_hit guard lets a genuine t of all-ones still win as the first hit
      if (qual && (!base_hit || cand_t_in < base_t)) begin
         nxt_block = cand_block_in;
         nxt_t     = cand_t_in;
         nxt_hit   = 1'b1;
      end
      nxt_cnt = (base_cnt == CNT_SAT) ? CNT_SAT : base_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= ST_FIRST;
         acc_block      <= MISS_IDX;
         acc_t          <= T_ALL1;
         acc_hit        <= 1'b0;
         acc_cnt        <= '0;
         acc_x          <= '0;
         acc_y          <= '0;
         res_valid_out  <= 1'b0;
         best_block_out <= MISS_IDX;
         best_t_out     <= T_ALL1;
         hit_out        <= 1'b0;
         x_out          <= '0;
         y_out          <= '0;
         count_err_out  <= 1'b0;
      end else begin
         if (res_valid_out && res_ready_in)
            res_valid_out <= 1'b0;
         if (beat_ok) begin
            if (cand_last_in) begin
               state          <= ST_FIRST;
               res_valid_out  <= 1'b1;
               best_block_out <= nxt_block;
               best_t_out     <= nxt_t;
               hit_out        <= nxt_hit;
               x_out          <= nxt_x;
               y_out          <= nxt_y;
               count_err_out  <= (nxt_cnt != CNT_GOOD);
            end else begin
               state     <= ST_ACCUM;
               acc_block <= nxt_block;
               acc_t     <= nxt_t;
               acc_hit   <= nxt_hit;
               acc_cnt   <= nxt_cnt;
               acc_x     <= nxt_x;
               acc_y     <= nxt_y;
            end
         end
      end
   end

endmodule

// File: tb/tb_nearest_block_reducer.sv
// Directed bench for nearest_block_reducer: stimulus pushes expected results into a
// scoreboard queue, a monitor compares every presented result against its head.
module tb_nearest_block_reducer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        cand_valid_in;
   logic        cand_ready_out;
   logic [3:0]  cand_block_in;
   logic        cand_hit_in;
   logic [31:0] cand_t_in;
   logic        cand_last_in;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic        res_valid_out;
   logic        res_ready_in;
   logic [3:0]  best_block_out;
   logic [31:0] best_t_out;
   logic        hit_out;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        count_err_out;

   nearest_block_reducer dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .cand_valid_in(cand_valid_in), .cand_ready_out(cand_ready_out),
      .cand_block_in(cand_block_in), .cand_hit_in(cand_hit_in),
      .cand_t_in(cand_t_in), .cand_last_in(cand_last_in),
      .x_in(x_in), .y_in(y_in),
      .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
      .best_block_out(best_block_out), .best_t_out(best_t_out),
      .hit_out(hit_out), .x_out(x_out), .y_out(y_out),
      .count_err_out(count_err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0]  blk;
      logic [31:0] t;
      logic        hit;
      logic [10:0] x;
      logic [9:0]  y;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic        stall_req = 1'b0;
   logic        hit_v[16];
   logic [31:0] t_v[16];

   // monitor: results are judged just before the edge that would complete the handshake
   always @(negedge clk_in) begin
      exp_t e;
      #3;
      if (rst_in === 1'b1 && res_valid_out === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result got blk=%0d t=%0h hit=%0b", best_block_out, best_t_out, hit_out);
         end else begin
            e = sb[0];
            if ({best_block_out, best_t_out, hit_out, x_out, y_out, count_err_out} !==
                {e.blk, e.t, e.hit, e.x, e.y, e.err}) begin
               fails++;
               $display("FAIL result got blk=%0d t=%0h hit=%0b x=%0d y=%0d err=%0b want blk=%0d t=%0h hit=%0b x=%0d y=%0d err=%0b",
                        best_block_out, best_t_out, hit_out, x_out, y_out, count_err_out,
                        e.blk, e.t, e.hit, e.x, e.y, e.err);
            end
            if (!res_ready_in) begin
               tests++;
               if (cand_ready_out !== 1'b0) begin
                  fails++;
                  $display("FAIL stall_ready got %0b want 0", cand_ready_out);
               end
            end else begin
               void'(sb.pop_front());
            end
         end
      end
   end

   // downstream: holds ready low for 5 cycles after the first result seen once armed
   initial begin
      res_ready_in = 1'b1;
      forever begin
         @(negedge clk_in);
         if (stall_req && res_valid_out) begin
            stall_req    = 1'b0;
            res_ready_in = 1'b0;
            repeat (5) @(negedge clk_in);
            res_ready_in = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic clear_vec();
      for (int i = 0; i < 16; i++) begin
         hit_v[i] = 1'b0;
         t_v[i]   = 32'd0;
      end
   endtask

   task automatic send_beat(input logic [3:0] blk, input logic hit, input logic [31:0] t,
                            input logic last, input logic [10:0] x, input logic [9:0] y);
      int waited = 0;
      @(negedge clk_in);
      cand_valid_in = 1'b1;
      cand_block_in = blk;
      cand_hit_in   = hit;
      cand_t_in     = t;
      cand_last_in  = last;
      x_in          = x;
      y_in          = y;
      #2;
      while (!cand_ready_out) begin
         waited++;
         if (waited > 100) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout got ready=0 want 1");
            break;
         end
         @(negedge clk_in);
         #2;
      end
      @(posedge clk_in);
      #1 cand_valid_in = 1'b0;
   endtask

   // later beats drive inverted coordinates so only the first-beat sample may reach the result
   task automatic send_pixel(input int n, input logic [10:0] x, input logic [9:0] y,
                             input logic [3:0] eb, input logic [31:0] et, input logic eh,
                             input logic ee);
      exp_t e;
      e.blk = eb; e.t = et; e.hit = eh; e.x = x; e.y = y; e.err = ee;
      sb.push_back(e);
      for (int i = 0; i < n; i++)
         send_beat(4'(i), hit_v[i], t_v[i], (i == n - 1), (i == 0) ? x : ~x, (i == 0) ? y : ~y);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_reset_vals();
      check("rst_valid", 64'(res_valid_out), 64'd0);
      check("rst_fields", {best_block_out, best_t_out, hit_out, count_err_out, x_out, y_out},
            {4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0, 11'd0, 10'd0});
   endtask

   initial begin
      rst_in = 1'b0;
      cand_valid_in = 1'b0; cand_block_in = '0; cand_hit_in = 1'b0;
      cand_t_in = '0; cand_last_in = 1'b0; x_in = '0; y_in = '0;
      #12;
      check_reset_vals();
      @(negedge clk_in);
      rst_in = 1'b1;

      // nearest of two hits, plus one-cycle latency
      clear_vec();
      hit_v[3] = 1'b1; t_v[3] = 32'd500;
      hit_v[7] = 1'b1; t_v[7] = 32'd200;
      send_pixel(12, 11'd256, 10'd200, 4'd7, 32'd200, 1'b1, 1'b0);
      check("latency_valid", 64'(res_valid_out), 64'd1);

      // all misses, then a hit below the near clip
      clear_vec();
      send_pixel(12, 11'd10, 10'd20, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);
      clear_vec();
      hit_v[5] = 1'b1; t_v[5] = 32'd0;
      send_pixel(12, 11'd11, 10'd21, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // tie keeps the earlier block
      clear_vec();
      hit_v[2] = 1'b1; t_v[2] = 32'd300;
      hit_v[9] = 1'b1; t_v[9] = 32'd300;
      send_pixel(12, 11'd2047, 10'd1023, 4'd2, 32'd300, 1'b1, 1'b0);
      wait_drain();

      // backpressure across back-to-back pixels; t equal to the clip still qualifies
      stall_req = 1'b1;
      clear_vec();
      hit_v[1] = 1'b1; t_v[1] = 32'd50;
      send_pixel(12, 11'd100, 10'd101, 4'd1, 32'd50, 1'b1, 1'b0);
      clear_vec();
      hit_v[11] = 1'b1; t_v[11] = 32'd1;
      hit_v[4]  = 1'b1; t_v[4]  = 32'd2;
      send_pixel(12, 11'd102, 10'd103, 4'd11, 32'd1, 1'b1, 1'b0);
      wait_drain();

      // short, long, normal and single-beat pixels
      clear_vec();
      hit_v[4] = 1'b1; t_v[4] = 32'd77;
      send_pixel(10, 11'd30, 10'd31, 4'd4, 32'd77, 1'b1, 1'b1);
      clear_vec();
      hit_v[0]  = 1'b1; t_v[0]  = 32'd900;
      hit_v[13] = 1'b1; t_v[13] = 32'd5;
      send_pixel(14, 11'd32, 10'd33, 4'd0, 32'd900, 1'b1, 1'b1);
      clear_vec();
      hit_v[11] = 1'b1; t_v[11] = 32'd1000;
      hit_v[10] = 1'b1; t_v[10] = 32'd999;
      send_pixel(12, 11'd34, 10'd35, 4'd10, 32'd999, 1'b1, 1'b0);
      clear_vec();
      hit_v[0] = 1'b1; t_v[0] = 32'd42;
      send_pixel(1, 11'd36, 10'd37, 4'd0, 32'd42, 1'b1, 1'b1);
      wait_drain();

      // async reset during beat 6 of a pixel full of near hits
      for (int i = 0; i < 6; i++)
         send_beat(4'(i), 1'b1, 32'd1, 1'b0, 11'd5, 10'd5);
      @(negedge clk_in);
      cand_valid_in = 1'b1; cand_block_in = 4'd6; cand_hit_in = 1'b1;
      cand_t_in = 32'd1; cand_last_in = 1'b0;
      #3 rst_in = 1'b0;
      #1 check_reset_vals();
      cand_valid_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      clear_vec();
      hit_v[8] = 1'b1; t_v[8] = 32'd123;
      send_pixel(12, 11'd40, 10'd41, 4'd8, 32'd123, 1'b1, 1'b0);
      wait_drain();

      repeat (3) @(negedge clk_in);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nearest_block_reducer.md
Name: nearest_block_reducer

Overview:
- Streaming min-reduction stage that sits directly after the per-block ray/box intersection unit in the ray-cast pipeline.
- Upstream sends one candidate beat per block for each pixel: block index, hit flag, fixed-point t, and a last marker.
- The block picks the nearest valid hit for that pixel and emits one result per pixel with the pixel coordinates attached, under ready/valid backpressure.
- It generalises the fixed 12-block nearest-hit selection to a parametrised block count, t width and near-clip threshold, and adds miss reporting, malformed-stream detection and backpressure.

Parameters:
- NUM_BLOCKS, 12, number of candidate beats expected per pixel; valid block indices are 0..NUM_BLOCKS-1.
- T_WIDTH, 32, width of unsigned fixed-point t.
- T_MIN, 1, near-clip threshold; a hit with t < T_MIN is treated as a miss.
- X_WIDTH, 11, pixel x width.
- Y_WIDTH, 10, pixel y width.
- IDX_W (localparam), $clog2(NUM_BLOCKS+1), width of block indices; wide enough to hold the miss sentinel NUM_BLOCKS.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- cand_valid_in  input  1  candidate beat valid
- cand_ready_out  output  1  candidate beat accepted when valid && ready
- cand_block_in  input  IDX_W  block index of the beat
- cand_hit_in  input  1  ray intersects this block
- cand_t_in  input  T_WIDTH  hit distance, unsigned
- cand_last_in  input  1  final beat of the pixel
- x_in  input  X_WIDTH  pixel x; sampled on the first beat of a pixel
- y_in  input  Y_WIDTH  pixel y; sampled on the first beat of a pixel
- res_valid_out  output  1  result valid
- res_ready_in  input  1  downstream accepts the result
- best_block_out  output  IDX_W  nearest block, or NUM_BLOCKS on a miss
- best_t_out  output  T_WIDTH  nearest t, or all-ones on a miss
- hit_out  output  1  at least one qualifying hit
- x_out  output  X_WIDTH  pixel x of the result
- y_out  output  Y_WIDTH  pixel y of the result
- count_err_out  output  1  beat count for the pixel was not NUM_BLOCKS

Behaviour:
- Reset: rst_in low clears all state immediately, asynchronously, including in mid-pixel. Output values during reset:
  - res_valid_out=0, hit_out=0, count_err_out=0
  - best_block_out=NUM_BLOCKS, best_t_out=all-ones
  - x_out=0, y_out=0
  - accumulator returns to FIRST and any partial pixel is discarded.
- cand_ready_out = !res_valid_out || res_ready_in. It is combinational from registered state and res_ready_in.
- Accumulator state machine:
  - FIRST: on an accepted beat, latch x_in/y_in, load the accumulator from the beat and set beat count to 1. Go to ACCUM if cand_last_in=0.
  - ACCUM: on an accepted beat, update the accumulator and count. Stay in ACCUM until an accepted beat has cand_last_in=1.
  - A last beat accepted in either state returns the machine to FIRST.
- A beat qualifies when cand_hit_in=1, cand_block_in < NUM_BLOCKS and cand_t_in >= T_MIN. Non-qualifying beats are counted but never replace the best.
- Replacement rule:
  - A qualifying beat replaces the best only if cand_t_in < best_t (strict compare).
  - On a tie the earlier beat wins.
  - The first qualifying beat of a pixel always loads.
  - The accumulator starts each pixel at all-ones and NUM_BLOCKS.
- Beat count saturates at NUM_BLOCKS+1. On the last beat, count_err = (final count != NUM_BLOCKS). A result is still produced.
- Result register:
  - Loads on the clock edge that accepts a last beat. Latency is 1 cycle from last-beat acceptance to res_valid_out=1.
  - hit_out=1 if any qualifying beat was seen; otherwise the miss sentinel values are reported.
  - Result fields are stable while res_valid_out && !res_ready_in.
  - res_valid_out clears on handshake unless a new last beat is accepted on the same edge. In that case the new result loads and res_valid_out stays 1.
- Throughput: one beat per cycle with no bubble between pixels when res_ready_in is held high. A single-beat pixel (first and last together) is legal.
- Backpressure: while cand_ready_out=0, no beat is consumed and accumulator state holds.

Test Plan:
- NUM_BLOCKS=12. Beats for blocks 0..11 with hits only on block 3 (t=500) and block 7 (t=200), pixel (256,200), res_ready_in=1 -> one cycle after the last beat: best_block_out=7, best_t_out=200, hit_out=1, (x_out,y_out)=(256,200), count_err_out=0.
- 12 beats with no hits, plus a second pixel where block 5 hits with t=0 (below T_MIN=1) -> both results report best_block_out=12, best_t_out=0xFFFFFFFF, hit_out=0.
- Tie: block 2 and block 9 both hit with t=300 -> best_block_out=2.
- Back-to-back pixels with res_ready_in low for 5 cycles after the first result -> first result held stable, cand_ready_out=0, no beats lost; second result appears after release; both results correct and in order.
- Last beat sent after only 10 beats, and a pixel with 14 beats -> count_err_out=1 on both, with correct best values. A 12-beat pixel immediately afterwards reports count_err_out=0.
- rst_in pulsed low during beat 6 of a pixel -> outputs take reset values immediately. A fresh 12-beat pixel after release yields a correct result with no influence from the aborted pixel.
